// File: rtl/tri_wave_ctrl_pkg.sv
// rtl/tri_wave_ctrl_pkg.sv - shared widths, constants and FSM encoding for the triangle wave controller
package tri_wave_ctrl_pkg;

  localparam int WAVE_W = 12;
  localparam int CFG_W  = 8;

  // Value the wave output parks at while the block is held in reset.
  localparam logic [WAVE_W-1:0] WAVE_MID = 12'h800;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Period counter increments but never wraps past all-ones.
  function automatic logic [CFG_W-1:0] sat_inc(input logic [CFG_W-1:0] v);
    return (v == {CFG_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tri_wave_ctrl_tick_div.sv
// rtl/tri_wave_ctrl_tick_div.sv - programmable tick divider, one tick every div+1 clocks
module tick_div
  import tri_wave_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CFG_W-1:0] div,
  output logic             tick
);

  logic [CFG_W-1:0] cnt;

  // No tick while held clear, so the first tick lands div+1 clocks after release.
  assign tick = !clr && (cnt == div);

  // Count 0..div, reloading 0 after the terminal count or whenever cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == div)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tri_wave_ctrl.sv
// rtl/tri_wave_ctrl.sv - triangle wave generator with config handshake, period counting and stop/done control
module tri_wave_ctrl
  import tri_wave_ctrl_pkg::*;
#(
  parameter logic [WAVE_W-1:0] DEF_LO   = 12'h000,
  parameter logic [WAVE_W-1:0] DEF_HI   = 12'hFFE,
  parameter logic [CFG_W-1:0]  DEF_STEP = 8'd2,
  parameter logic [CFG_W-1:0]  DEF_DIV  = 8'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WAVE_W-1:0] cfg_lo,
  input  logic [WAVE_W-1:0] cfg_hi,
  input  logic [CFG_W-1:0]  cfg_step,
  input  logic [CFG_W-1:0]  cfg_div,
  input  logic [CFG_W-1:0]  cfg_periods,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [WAVE_W-1:0] wave,
  output logic              sample_strobe,
  output logic [CFG_W-1:0]  period_cnt
);

  state_t            state, state_n;
  logic [WAVE_W-1:0] lo_q, hi_q, lo_n, hi_n;
  logic [CFG_W-1:0]  step_q, div_q, per_q, step_n, div_n, per_n;
  logic [WAVE_W-1:0] wave_n;
  logic [CFG_W-1:0]  pcnt_n, pcnt_inc;
  logic              strobe_n, done_n, err_n;
  logic [WAVE_W:0]   sum, diff;
  logic              tick, div_clr;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // The divider only runs while the wave is actually moving.
  assign div_clr = (state == IDLE) || (state == FINISH);

  tick_div u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .div   (div_q),
    .tick  (tick)
  );

  // State, wave datapath and config registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wave          <= WAVE_MID;
      sample_strobe <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      period_cnt    <= '0;
      lo_q          <= DEF_LO;
      hi_q          <= DEF_HI;
      step_q        <= DEF_STEP;
      div_q         <= DEF_DIV;
      per_q         <= '0;
    end else begin
      state         <= state_n;
      wave          <= wave_n;
      sample_strobe <= strobe_n;
      done          <= done_n;
      cfg_err       <= err_n;
      period_cnt    <= pcnt_n;
      lo_q          <= lo_n;
      hi_q          <= hi_n;
      step_q        <= step_n;
      div_q         <= div_n;
      per_q         <= per_n;
    end
  end

  // Next-state, next-wave and pulse generation; 13-bit arithmetic keeps the
  // edge compares free of overflow and underflow wrap.
  always_comb begin
    state_n  = state;
    wave_n   = wave;
    pcnt_n   = period_cnt;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    lo_n     = lo_q;
    hi_n     = hi_q;
    step_n   = step_q;
    div_n    = div_q;
    per_n    = per_q;
    sum      = {1'b0, wave} + {{(WAVE_W+1-CFG_W){1'b0}}, step_q};
    diff     = {1'b0, wave} - {{(WAVE_W+1-CFG_W){1'b0}}, step_q};
    pcnt_inc = sat_inc(period_cnt);

    case (state)
      IDLE: begin
        if (cfg_valid) begin
          if ((cfg_step == '0) || (cfg_lo >= cfg_hi)) begin
            err_n = 1'b1;
          end else begin
            lo_n   = cfg_lo;
            hi_n   = cfg_hi;
            step_n = cfg_step;
            div_n  = cfg_div;
            per_n  = cfg_periods;
          end
        end
        if (start && !stop) begin
          state_n  = UP;
          wave_n   = lo_q;
          pcnt_n   = '0;
          strobe_n = 1'b1;
        end
      end

      UP: begin
        if (stop) begin
          state_n = IDLE;
          wave_n  = lo_q;
        end else if (tick) begin
          strobe_n = 1'b1;
          if (sum >= {1'b0, hi_q}) begin
            wave_n  = hi_q;
            state_n = DOWN;
          end else begin
            wave_n = sum[WAVE_W-1:0];
          end
        end
      end

      DOWN: begin
        if (stop) begin
          state_n = IDLE;
          wave_n  = lo_q;
        end else if (tick) begin
          strobe_n = 1'b1;
          if ($signed(diff) <= $signed({1'b0, lo_q})) begin
            wave_n = lo_q;
            pcnt_n = pcnt_inc;
            if ((per_q != '0) && (pcnt_inc == per_q)) begin
              state_n = FINISH;
              done_n  = 1'b1;
            end else begin
              state_n = UP;
            end
          end else begin
            wave_n = diff[WAVE_W-1:0];
          end
        end
      end

      FINISH: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tri_wave_ctrl.sv
// tb/tb_tri_wave_ctrl.sv - self-checking bench for tri_wave_ctrl with table, random and corner sequences
module tb_tri_wave_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [11:0] cfg_lo = '0, cfg_hi = '0;
  logic [7:0]  cfg_step = '0, cfg_div = '0, cfg_periods = '0;
  logic        start = 1'b0, stop = 1'b0;
  logic        cfg_ready, cfg_err, busy, done, sample_strobe;
  logic [11:0] wave;
  logic [7:0]  period_cnt;

  tri_wave_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_step(cfg_step), .cfg_div(cfg_div),
    .cfg_periods(cfg_periods), .cfg_err(cfg_err),
    .start(start), .stop(stop), .busy(busy), .done(done),
    .wave(wave), .sample_strobe(sample_strobe), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  int model_periods;
  int run_nsamp;
  int cur_lo = 0, cur_hi = 4094, cur_step = 2, cur_div = 1, cur_per = 0;

  typedef struct {
    int lo; int hi; int step; int div; int per;
    bit exp_err; int exp_pcnt; int exp_nsamp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected wave sample list from the climb/fall rules with plain integers.
  task automatic build_model(input int lo, input int hi, input int step, input int periods, input int max_n);
    int v;
    exp_q.delete();
    model_periods = 0;
    v = lo;
    exp_q.push_back(lo);
    while (exp_q.size() < max_n) begin
      while ((v + step < hi) && (exp_q.size() < max_n)) begin
        v = v + step;
        exp_q.push_back(v);
      end
      if (exp_q.size() >= max_n) break;
      v = hi;
      exp_q.push_back(v);
      while ((v - step > lo) && (exp_q.size() < max_n)) begin
        v = v - step;
        exp_q.push_back(v);
      end
      if (exp_q.size() >= max_n) break;
      v = lo;
      exp_q.push_back(v);
      model_periods++;
      if ((periods != 0) && (model_periods == periods)) break;
    end
  endtask

  task automatic apply_cfg(input int lo, input int hi, input int step, input int div, input int per, input bit exp_err);
    int w;
    w = 0;
    while (!cfg_ready && w < 1000) begin @(negedge clk); w++; end
    check("cfg_ready_wait", cfg_ready, 1);
    cfg_lo = lo[11:0]; cfg_hi = hi[11:0]; cfg_step = step[7:0];
    cfg_div = div[7:0]; cfg_periods = per[7:0];
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_err_pulse", cfg_err, exp_err);
    @(negedge clk);
    check("cfg_err_single", cfg_err, 0);
    if (!exp_err) begin
      cur_lo = lo; cur_hi = hi; cur_step = step; cur_div = div; cur_per = per;
    end
  endtask

  // Start a run and compare every strobed sample against exp_q.
  task automatic run_wave(input int max_n, input bit expect_done);
    int idx, last;
    bit seen_done;
    idx = 0; last = 0; seen_done = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (sample_strobe) begin
        if (idx < exp_q.size()) check("wave_sample", wave, exp_q[idx]);
        else check("extra_sample", idx, exp_q.size());
        if (idx > 0) check("strobe_gap", cyc - last, cur_div + 1);
        else check("first_strobe_cycle", cyc, 0);
        last = cyc;
        idx++;
      end
      if (done) begin
        seen_done = 1;
        check("done_wave_lo", wave, cur_lo);
        check("done_busy", busy, 1);
        break;
      end
      if (!expect_done && idx >= max_n) break;
    end
    run_nsamp = idx;
    check("done_expected", seen_done, expect_done);
    check("sample_count", idx, exp_q.size());
    if (expect_done) begin
      @(negedge clk);
      check("done_single", done, 0);
      check("busy_after_done", busy, 0);
      check("wave_hold_lo", wave, cur_lo);
      check("period_cnt_final", period_cnt, model_periods);
    end else begin
      check("period_cnt_run", period_cnt, model_periods);
      check("busy_running", busy, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_wave", wave, cur_lo);
      check("stop_no_done", done, 0);
    end
  endtask

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int w, lo, hi, step, div, per;
    bit err;

    vecs[0] = '{100, 110, 3, 0, 2, 0, 2, 17};
    vecs[1] = '{200, 100, 3, 0, 5, 1, 2, 17};
    vecs[2] = '{10, 50, 0, 0, 1, 1, 2, 17};
    vecs[3] = '{50, 50, 1, 0, 1, 1, 2, 17};
    vecs[4] = '{0, 4, 4, 0, 255, 0, 255, 511};
    vecs[5] = '{4000, 4095, 255, 2, 3, 0, 3, 7};
    vecs[6] = '{0, 1, 1, 3, 1, 0, 1, 3};
    vecs[7] = '{4095, 0, 1, 0, 9, 1, 1, 3};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_wave", wave, 12'h800);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_strobe", sample_strobe, 0);
    check("rst_pcnt", period_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default continuous run through one full period
    build_model(cur_lo, cur_hi, cur_step, 0, 4097);
    run_wave(4097, 0);

    // Stop while climbing at 0x400
    start = 1'b1; @(negedge clk); start = 1'b0;
    w = 0;
    while (!(wave == 12'h400 && busy) && w < 5000) begin @(negedge clk); w++; end
    check("reach_0x400", wave, 12'h400);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check("stop_up_busy", busy, 0);
    check("stop_up_wave", wave, 0);
    check("stop_up_done", done, 0);
    repeat (3) begin @(negedge clk); check("stop_up_no_done", done, 0); end

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_strobe", sample_strobe, 0);
    @(negedge clk);
    check("startstop_busy2", busy, 0);

    // Table of configs: accept/reject and the resulting run
    for (int i = 0; i < 8; i++) begin
      apply_cfg(vecs[i].lo, vecs[i].hi, vecs[i].step, vecs[i].div, vecs[i].per, vecs[i].exp_err);
      build_model(cur_lo, cur_hi, cur_step, cur_per, 100000);
      run_wave(100000, 1);
      check("tbl_pcnt", period_cnt, vecs[i].exp_pcnt);
      check("tbl_nsamp", run_nsamp, vecs[i].exp_nsamp);
    end

    // Config offered while busy is ignored
    start = 1'b1; @(negedge clk); start = 1'b0;
    cfg_lo = 12'd5; cfg_hi = 12'd9; cfg_step = 8'd1; cfg_div = 8'd0; cfg_periods = 8'd4;
    cfg_valid = 1'b1;
    repeat (2) begin
      check("busy_cfg_ready", cfg_ready, 0);
      @(negedge clk);
      check("busy_cfg_err", cfg_err, 0);
    end
    cfg_valid = 1'b0;
    w = 0;
    while (busy && w < 1000) begin @(negedge clk); w++; end
    check("busy_cfg_end", busy, 0);
    build_model(cur_lo, cur_hi, cur_step, cur_per, 100000);
    run_wave(100000, 1);

    // Randomized configs, some deliberately invalid
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        lo = $urandom_range(1, 4095);
        hi = $urandom_range(0, lo);
        step = $urandom_range(0, 255);
      end else begin
        lo = $urandom_range(0, 4000);
        hi = lo + $urandom_range(1, 95);
        step = $urandom_range(1, 255);
      end
      div = $urandom_range(0, 3);
      per = $urandom_range(1, 3);
      err = (step == 0) || (lo >= hi);
      apply_cfg(lo, hi, step, div, per, err);
      build_model(cur_lo, cur_hi, cur_step, cur_per, 100000);
      run_wave(100000, 1);
    end

    // Asynchronous reset while falling
    apply_cfg(0, 100, 10, 0, 0, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    w = 0;
    while (wave != 12'd100 && w < 200) begin @(negedge clk); w++; end
    check("reach_peak", wave, 100);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_wave", wave, 12'h800);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_pcnt", period_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", busy, 0);
      check("post_rst_nodone", done, 0);
    end
    cur_lo = 0; cur_hi = 4094; cur_step = 2; cur_div = 1; cur_per = 0;
    build_model(cur_lo, cur_hi, cur_step, 0, 6);
    run_wave(6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_wave_ctrl.md
TRI_WAVE_CTRL -- requirements
Module: tri_wave_ctrl

Interface
REQ-001 SHALL have parameter DEF_LO, default 12'h000, meaning the reset lower bound of the wave.
REQ-002 SHALL have parameter DEF_HI, default 12'hFFE, meaning the reset upper bound of the wave.
REQ-003 SHALL have parameter DEF_STEP, default 8'd2, meaning the reset increment per tick.
REQ-004 SHALL have parameter DEF_DIV, default 8'd1, meaning the reset tick divider (update rate clk/(div+1)).
REQ-005 SHALL have ports: clk in 1, the single clock; rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: cfg_valid in 1, config offered; cfg_ready out 1, config accepted this cycle when both are high.
REQ-007 SHALL have ports: cfg_lo in 12, cfg_hi in 12, cfg_step in 8, cfg_div in 8, and cfg_periods in 8 (0 = continuous).
REQ-008 SHALL have ports: cfg_err out 1, single-cycle pulse flagging a rejected config.
REQ-009 SHALL have ports: start in 1, stop in 1, busy out 1, and done out 1 (single-cycle pulse).
REQ-010 SHALL have ports: wave out 12, registered sample; sample_strobe out 1, pulse on every wave update; period_cnt out 8, completed periods.

Function
REQ-011 FSM states SHALL be IDLE, UP, DOWN and FINISH; cfg_ready SHALL equal (state==IDLE).
REQ-012 Config with step==0 or lo>=hi SHALL be rejected: cfg_err pulses one cycle after the handshake and the registers are unchanged.
REQ-013 A valid config handshake SHALL update all five config registers on the same edge.
REQ-014 start in IDLE SHALL, on the next edge: set wave=lo, enter UP, set busy=1, clear period_cnt, clear the divider and pulse sample_strobe.
REQ-015 The divider SHALL count 0..div; a tick SHALL occur when counter==div, then the counter reloads 0; the first tick comes div+1 clocks after start.
REQ-016 UP on tick: if wave+step >= hi (13-bit compare), wave=hi and enter DOWN; else wave+=step.
REQ-017 DOWN on tick: if wave-step <= lo (13-bit signed compare, no underflow wrap), wave=lo, period_cnt+=1 (saturating at 255) and enter UP.
REQ-018 When periods!=0 and period_cnt reaches periods, the FSM SHALL enter FINISH instead of UP.
REQ-019 FINISH SHALL last one cycle, pulse done, then return to IDLE; wave SHALL hold lo.
REQ-020 sample_strobe SHALL pulse exactly on the cycle wave changes register value due to a start or a tick.
REQ-021 stop while busy SHALL force IDLE on the next edge with wave=lo and no done pulse; stop and start together in IDLE SHALL be ignored.
REQ-022 start while busy and cfg_valid while busy SHALL be ignored (cfg_ready=0).
REQ-023 busy SHALL be 1 in UP, DOWN and FINISH, and 0 in IDLE.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, wave=12'h800, sample_strobe=0, done=0, cfg_err=0, busy=0, period_cnt=0, divider=0.
REQ-025 On rst_n low, config registers SHALL load DEF_LO, DEF_HI, DEF_STEP, DEF_DIV and periods=0.
REQ-026 Reset asserted mid-run SHALL abort without a done pulse; after release, the block SHALL await start.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the 12-bit wave width, the 8-bit config width and the midscale constant 12'h800.
REQ-028 The divider SHALL be one sub-module, tick_div (clk, rst_n, clr, div, tick); the rest is flat.

Verification
REQ-029 Defaults, start -> wave 0,2,4.. updating every 2 clk, peak 0xFFE, returns to 0, period_cnt=1, sample_strobe each update.
REQ-030 cfg lo=100, hi=110, step=3, div=0, periods=2 -> 100,103,106,109,110,107,104,101,100 twice, then done pulse, busy=0, period_cnt=2.
REQ-031 cfg lo=200, hi=100 (and separately step=0) -> cfg_err pulse; a subsequent run still uses the prior config.
REQ-032 stop asserted mid-UP at wave=0x400 -> next edge IDLE, wave=lo, no done; start+stop together in IDLE -> stays IDLE.
REQ-033 rst_n pulsed low mid-DOWN (async, between edges) -> wave=0x800, busy=0 immediately; cfg_valid while busy -> cfg_ready=0, config unchanged.
REQ-034 periods=255 with lo=0, hi=4, step=4 -> done after the 255th return to lo; period_cnt never wraps.
